// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache requests onto one variable-latency RAM port.
// Data wins by default; a starvation guard forces an instruction grant after STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic        mem_error
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [31:0]   TMO_DATA   = 32'hBAD1BAD1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [31:0]     r_addr;
  logic [31:0]     r_store;
  logic            r_op;
  logic [SW-1:0]   r_starve_cnt;
  logic [TW-1:0]   r_tmo_cnt;
  logic            r_mem_error;

  logic            w_d_pend;
  logic            w_i_forced;
  logic            w_grant;
  logic            w_tmo_hit;
  logic            w_done;

  assign w_d_pend   = dREN | dWEN;
  assign w_i_forced = iREN && (r_starve_cnt == STARVE_MAX);
  assign w_grant    = (r_state != IDLE);
  assign w_tmo_hit  = w_grant && (r_tmo_cnt == TMO_LAST) && !ramready;
  assign w_done     = w_grant && (ramready || w_tmo_hit);

  // RAM only ever sees the values latched at grant entry
  assign ramaddr   = r_addr;
  assign ramstore  = r_store;
  assign mem_error = r_mem_error;

  always_comb begin
    w_next = r_state;
    iwait  = 1'b1;
    dwait  = 1'b1;
    iload  = 32'h0;
    dload  = 32'h0;
    ramREN = 1'b0;
    ramWEN = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_d_pend && !w_i_forced) begin
          w_next = DGRANT;
        end else if (iREN) begin
          w_next = IGRANT;
        end
      end
      IGRANT: begin
        ramREN = 1'b1;
        if (w_done) begin
          w_next = IDLE;
          iwait  = 1'b0;
          iload  = ramready ? ramload : TMO_DATA;
        end
      end
      DGRANT: begin
        ramWEN = r_op;
        ramREN = ~r_op;
        if (w_done) begin
          w_next = IDLE;
          dwait  = 1'b0;
          if (!r_op) begin
            dload = ramready ? ramload : TMO_DATA;
          end
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_addr       <= 32'h0;
      r_store      <= 32'h0;
      r_op         <= 1'b0;
      r_starve_cnt <= '0;
      r_tmo_cnt    <= '0;
      r_mem_error  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_tmo_hit) begin
        r_mem_error <= 1'b1;
      end
      if (r_state == IDLE) begin
        r_tmo_cnt <= '0;
        if (w_next == DGRANT) begin
          r_addr  <= daddr;
          r_store <= dstore;
          r_op    <= dWEN;
          // only data grants that bypass a waiting fetch count toward starvation
          if (iREN && (r_starve_cnt != STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
          end
        end else if (w_next == IGRANT) begin
          r_addr       <= iaddr;
          r_store      <= dstore;
          r_op         <= 1'b0;
          r_starve_cnt <= '0;
        end
      end else if (!ramready) begin
        r_tmo_cnt <= r_tmo_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cases first, then randomized traffic checked by a
// transaction-level model feeding scoreboard queues that a negedge monitor drains.
module tb_mem_arbiter;

  localparam int SL  = 2;
  localparam int TMO = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;
  logic        mem_error;

  mem_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .mem_error(mem_error)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
  } ram_e_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } rsp_e_t;

  ram_e_t ram_q[$];
  rsp_e_t i_q[$];
  rsp_e_t d_q[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  // reference model state: who owns the RAM, how long, and each client's pending request
  int          m_own;
  int          m_k;
  int          m_lat;
  int          m_starve;
  logic        m_err;
  logic        m_op;
  logic [31:0] m_addr;
  logic [31:0] m_store;
  bit          ip, dp, dop;
  int          igap, dgap;
  logic [31:0] ia, da, dd;
  logic [31:0] mem [logic [31:0]];

  task automatic check(input string nm, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] rdval(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC0DE5A00;
  endfunction

  always @(negedge CLK) begin : monitor
    ram_e_t m;
    rsp_e_t r;
    if (mon_en) begin
      while (ram_q.size() > 0 && ram_q[0].cyc < cyc) begin
        m = ram_q.pop_front();
        check("ram_missed_cycle", 96'(cyc), 96'(m.cyc));
      end
      while (i_q.size() > 0 && i_q[0].cyc < cyc) begin
        r = i_q.pop_front();
        check("i_missed_cycle", 96'(cyc), 96'(r.cyc));
      end
      while (d_q.size() > 0 && d_q[0].cyc < cyc) begin
        r = d_q.pop_front();
        check("d_missed_cycle", 96'(cyc), 96'(r.cyc));
      end
      if (ramREN || ramWEN) begin
        if (ram_q.size() > 0 && ram_q[0].cyc == cyc) begin
          m = ram_q.pop_front();
          check("ram_access", 96'({ramREN, ramWEN, ramaddr, ramWEN ? ramstore : 32'h0}),
                96'({m.ren, m.wen, m.addr, m.wen ? m.store : 32'h0}));
        end else begin
          check("ram_unexpected_cycle", 96'(cyc), 96'(-1));
        end
      end
      if (!iwait) begin
        if (i_q.size() > 0 && i_q[0].cyc == cyc) begin
          r = i_q.pop_front();
          check("i_rsp", 96'({iload, mem_error}), 96'({r.data, r.err}));
        end else begin
          check("i_unexpected_cycle", 96'(cyc), 96'(-1));
        end
      end else begin
        check("iload_while_wait", 96'(iload), 96'(0));
      end
      if (!dwait) begin
        if (d_q.size() > 0 && d_q[0].cyc == cyc) begin
          r = d_q.pop_front();
          check("d_rsp", 96'({dload, mem_error}), 96'({r.data, r.err}));
        end else begin
          check("d_unexpected_cycle", 96'(cyc), 96'(-1));
        end
      end else begin
        check("dload_while_wait", 96'(dload), 96'(0));
      end
    end
  end

  // One call = ncyc cycles of traffic. Clients start requests with probability p_req and
  // hold them until the model says they completed; RAM latency is fix_lat or random 1..6.
  task automatic run_model(input int ncyc, input int p_req, input int gmax,
                           input bit i_on, input bit d_on, input int fix_lat);
    logic        rdy;
    logic [31:0] ld;
    ram_e_t      m;
    rsp_e_t      r;
    for (int n = 0; n < ncyc; n++) begin
      step();
      if (!ip) begin
        if (igap > 0) igap--;
        else if (i_on && $urandom_range(99) < p_req) begin
          ip = 1'b1;
          ia = {24'h000000, 6'($urandom), 2'b00};
        end
      end
      if (!dp) begin
        if (dgap > 0) dgap--;
        else if (d_on && $urandom_range(99) < p_req) begin
          dp  = 1'b1;
          dop = 1'($urandom_range(1));
          da  = {24'h100000, 6'($urandom), 2'b00};
          dd  = $urandom();
        end
      end
      iREN   = ip;
      iaddr  = ip ? ia : $urandom();
      dWEN   = dp && dop;
      dREN   = dp && (!dop || $urandom_range(1) != 0);
      daddr  = dp ? da : $urandom();
      dstore = dp ? dd : $urandom();

      ld  = $urandom();
      rdy = 1'b0;
      if (m_own != 0) begin
        rdy = (m_k == m_lat);
        if (rdy && !m_op) ld = rdval(m_addr);
        m.cyc = cyc; m.ren = !m_op; m.wen = m_op; m.addr = m_addr; m.store = m_store;
        ram_q.push_back(m);
        if (rdy || m_k == TMO) begin
          r.cyc  = cyc;
          r.err  = m_err;
          r.data = m_op ? 32'h0 : (rdy ? ld : 32'hBAD1BAD1);
          if (m_own == 1) begin
            i_q.push_back(r);
            ip   = 1'b0;
            igap = $urandom_range(gmax);
          end else begin
            d_q.push_back(r);
            dp   = 1'b0;
            dgap = $urandom_range(gmax);
          end
          if (!rdy) m_err = 1'b1;
          else if (m_op) mem[m_addr] = m_store;
          m_own = 0;
        end else begin
          m_k++;
        end
      end else begin
        rdy = ($urandom_range(3) == 0);
        if (dp && !(ip && m_starve == SL)) begin
          m_own = 2; m_addr = da; m_store = dd; m_op = dop;
          if (ip && m_starve < SL) m_starve++;
        end else if (ip) begin
          m_own = 1; m_addr = ia; m_store = 32'h0; m_op = 1'b0;
          m_starve = 0;
        end
        if (m_own != 0) begin
          m_k   = 1;
          m_lat = (fix_lat != 0) ? fix_lat : int'($urandom_range(6, 1));
        end
      end
      ramready = rdy;
      ramload  = ld;
    end
  endtask

  initial begin
    RST = 1'b1; iREN = 1'b0; iaddr = 32'h0; dREN = 1'b0; dWEN = 1'b0;
    daddr = 32'h0; dstore = 32'h0; ramload = 32'h0; ramready = 1'b0;
    step(); step();
    @(negedge CLK);
    check("rst_waits", 96'({iwait, dwait}), 96'(2'b11));
    check("rst_loads", 96'({iload, dload}), 96'(0));
    check("rst_ram_err", 96'({ramREN, ramWEN, ramaddr, ramstore, mem_error}), 96'(0));

    // instruction read, RAM ready on the third enable cycle
    step(); RST = 1'b0; iREN = 1'b1; iaddr = 32'h40;
    for (int k = 1; k <= 3; k++) begin
      step();
      ramready = (k == 3);
      ramload  = (k == 3) ? 32'h8C010004 : 32'h0;
      @(negedge CLK);
      check("iread_enable", 96'({ramREN, ramWEN, ramaddr}), 96'({2'b10, 32'h40}));
      check("iread_rsp", 96'({iwait, iload}),
            (k == 3) ? 96'({1'b0, 32'h8C010004}) : 96'({1'b1, 32'h0}));
    end
    step(); iREN = 1'b0; ramready = 1'b0;
    @(negedge CLK);
    check("iread_idle_after", 96'({ramREN, iwait}), 96'(2'b01));

    // write, zero-wait RAM
    step(); dREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    step(); ramready = 1'b1; ramload = 32'h5555AAAA;
    @(negedge CLK);
    check("write_ram", 96'({ramREN, ramWEN, ramaddr, ramstore}), 96'({2'b01, 32'h100, 32'hDEADBEEF}));
    check("write_rsp", 96'({dwait, dload}), 96'(0));
    step(); dREN = 1'b0; dWEN = 1'b0; ramready = 1'b0;
    @(negedge CLK);
    check("write_idle_after", 96'({ramWEN, dwait}), 96'(2'b01));

    // data read that never gets ramready
    step(); dREN = 1'b1; daddr = 32'h200;
    for (int k = 1; k <= TMO; k++) begin
      step();
      ramload = $urandom();
      @(negedge CLK);
      check("tmo_enable", 96'({ramREN, ramaddr}), 96'({1'b1, 32'h200}));
      check("tmo_rsp", 96'({dwait, dload, mem_error}),
            (k == TMO) ? 96'({1'b0, 32'hBAD1BAD1, 1'b0}) : 96'({1'b1, 32'h0, 1'b0}));
    end
    step(); daddr = 32'h80;
    @(negedge CLK);
    check("tmo_sticky_idle", 96'({mem_error, ramREN, dwait}), 96'(3'b101));

    // reset in the second cycle of a data grant, then a stray ramready
    step();
    @(negedge CLK);
    check("rst_mid_grant1", 96'({ramREN, ramaddr, dwait}), 96'({1'b1, 32'h80, 1'b1}));
    step(); RST = 1'b1;
    @(negedge CLK);
    check("rst_mid_grant2", 96'({ramREN, mem_error, dwait}), 96'(3'b111));
    step(); RST = 1'b0; ramready = 1'b1; ramload = 32'h12345678;
    @(negedge CLK);
    check("rst_mid_after", 96'({ramREN, ramWEN, dwait, dload, mem_error}), 96'({3'b001, 32'h0, 1'b0}));
    step();
    @(negedge CLK);
    check("rst_rearbitrate", 96'({ramREN, ramaddr, dwait, dload}), 96'({1'b1, 32'h80, 1'b0, 32'h12345678}));
    step(); dREN = 1'b0; ramready = 1'b0;
    step(); RST = 1'b1;
    step(); RST = 1'b0;

    m_own = 0; m_k = 0; m_lat = 1; m_starve = 0; m_err = 1'b0; m_op = 1'b0;
    m_addr = 32'h0; m_store = 32'h0;
    ip = 1'b0; dp = 1'b0; dop = 1'b0; igap = 0; dgap = 0;
    ia = 32'h0; da = 32'h0; dd = 32'h0;
    mon_en = 1'b1;

    run_model(60, 100, 0, 1'b1, 1'b1, 1);     // both held, zero-wait: D,D,I pattern
    run_model(1500, 40, 3, 1'b1, 1'b1, 0);    // mixed traffic with random latency
    run_model(30, 100, 0, 1'b0, 1'b1, 6);     // every access times out
    run_model(40, 0, 0, 1'b0, 1'b0, 0);       // drain
    step();
    @(negedge CLK);
    check("ram_q_drained", 96'(ram_q.size()), 96'(0));
    check("i_q_drained", 96'(i_q.size()), 96'(0));
    check("d_q_drained", 96'(d_q.size()), 96'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
